adc_frame_rx: RTL and testbench

//  Receiver for the ADC serial data frame output (DCLK/DRDY/D0..D4) in the clk_ctrl domain.

---
 rtl/adc_frame_rx.sv | 118 +++++++++++
 tb/tb_adc_frame_rx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/adc_frame_rx.sv
// adc_frame_rx: oversampled DCLK/DRDY serial frame receiver delivering per-lane header and data words
// Optional per-lane header validation is enabled by defining ADC_RX_HDR_CHECK_EN.
module adc_frame_rx #(
  parameter int LANES   = 5,
  parameter int HDR_W   = 8,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_ctrl,
  input  logic                      rst_n,
  input  logic                      dclk,
  input  logic                      drdy,
  input  logic [LANES-1:0]          adc_d,
  output logic [LANES*DATA_W-1:0]   sample_data,
  output logic [LANES*HDR_W-1:0]    sample_hdr,
  output logic                      sample_valid,
  output logic                      frame_err,
  output logic [7:0]                err_count,
  output logic [1:0]                rx_state
);
  localparam int FRAME_BITS = HDR_W + DATA_W;
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  (* ASYNC_REG = "TRUE" *) logic [2:0] dclk_s;
  (* ASYNC_REG = "TRUE" *) logic [1:0] drdy_s;
  (* ASYNC_REG = "TRUE" *) logic [LANES-1:0] d_s0, d_s1;
  logic [1:0] state, state_n;
  logic [CW-1:0] bit_cnt, bit_n;
  logic [7:0] tmo, tmo_n;
  logic [LANES-1:0][FRAME_BITS-1:0] sr, sr_sh, sr_n;
  logic [LANES*HDR_W-1:0] hdr_flat;
  logic [LANES*DATA_W-1:0] data_flat;
  logic re, drdy_r, hdr_bad, err_n, valid_n;
  // data and drdy come from the same sync stage as the detected edge so all lanes align
  assign re = dclk_s[1] & ~dclk_s[2];
  assign drdy_r = drdy_s[1];
  assign rx_state = state;
  always_comb begin
    hdr_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      sr_sh[i] = {sr[i][FRAME_BITS-2:0], d_s1[i]};
      hdr_flat[i*HDR_W +: HDR_W] = sr_sh[i][FRAME_BITS-1 -: HDR_W];
      data_flat[i*DATA_W +: DATA_W] = sr_sh[i][DATA_W-1:0];
`ifdef ADC_RX_HDR_CHECK_EN
      hdr_bad = hdr_bad | sr_sh[i][FRAME_BITS-1] | (sr_sh[i][FRAME_BITS-2 -: 3] != 3'(i));
`endif
    end
  end
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    tmo_n = tmo;
    sr_n = sr;
    err_n = 1'b0;
    valid_n = 1'b0;
    if (state == SHIFT) begin
      tmo_n = re ? 8'd0 : tmo + 8'd1;
      if (re) begin
        sr_n = sr_sh;
        err_n = drdy_r;
        bit_n = drdy_r ? CW'(1) : bit_cnt + CW'(1);
        if (!drdy_r && bit_cnt == CW'(FRAME_BITS - 1)) begin
          state_n = DONE;
          err_n = hdr_bad;
          valid_n = ~hdr_bad;
        end
      end else if (tmo == 8'(TIMEOUT - 1)) begin
        err_n = 1'b1;
        bit_n = '0;
        state_n = IDLE;
      end
    end else begin
      if (state == DONE) begin
        state_n = IDLE;
        bit_n = '0;
      end
      if (re && drdy_r) begin
        sr_n = sr_sh;
        bit_n = CW'(1);
        tmo_n = 8'd0;
        state_n = SHIFT;
      end
    end
  end
  always_ff @(posedge clk_ctrl) begin
    if (!rst_n) begin
      dclk_s <= '0;
      drdy_s <= '0;
      d_s0 <= '0;
      d_s1 <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      tmo <= '0;
      sr <= '0;
      sample_data <= '0;
      sample_hdr <= '0;
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      dclk_s <= {dclk_s[1:0], dclk};
      drdy_s <= {drdy_s[0], drdy};
      d_s0 <= adc_d;
      d_s1 <= d_s0;
      state <= state_n;
      bit_cnt <= bit_n;
      tmo <= tmo_n;
      sr <= sr_n;
      sample_valid <= valid_n;
      frame_err <= err_n;
      if (valid_n) begin
        sample_data <= data_flat;
        sample_hdr <= hdr_flat;
      end
      if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_adc_frame_rx.sv
// tb_adc_frame_rx: scoreboard bench driving serial ADC frames at dclk = clk_ctrl/8
module tb_adc_frame_rx;
  localparam int LANES = 5, HDR_W = 8, DATA_W = 24;
  typedef logic [LANES-1:0][31:0] frame_t;
  typedef struct packed {
    logic [LANES*DATA_W-1:0] data;
    logic [LANES*HDR_W-1:0]  hdr;
  } exp_t;
  logic clk_ctrl = 1'b0, rst_n = 1'b0, dclk = 1'b0, drdy = 1'b0;
  logic [LANES-1:0] adc_d = '0;
  logic [LANES*DATA_W-1:0] sample_data;
  logic [LANES*HDR_W-1:0] sample_hdr;
  logic sample_valid, frame_err;
  logic [7:0] err_count;
  logic [1:0] rx_state;
  exp_t q[$];
  exp_t got_e;
  int checks = 0, errors = 0, exp_errs = 0, obs_errs = 0, vcount = 0;
  always #5 clk_ctrl = ~clk_ctrl;
  adc_frame_rx dut (
    .clk_ctrl(clk_ctrl), .rst_n(rst_n), .dclk(dclk), .drdy(drdy), .adc_d(adc_d),
    .sample_data(sample_data), .sample_hdr(sample_hdr), .sample_valid(sample_valid),
    .frame_err(frame_err), .err_count(err_count), .rx_state(rx_state)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic frame_t mk(input int k);
    frame_t r;
    for (int i = 0; i < LANES; i++)
      r[i] = {8'(i << 4), 24'hA5A5A0 + 24'(i) + 24'(k * 32'h111111)};
    return r;
  endfunction
  task automatic send_bit(input logic r, input logic [LANES-1:0] d);
    dclk = 1'b0; drdy = r; adc_d = d;
    #40;
    dclk = 1'b1;
    #40;
  endtask
  task automatic send_frame(input frame_t fw, input int nbits, input logic good);
    exp_t e;
    logic [LANES-1:0] d;
    if (nbits == 32 && good) begin
      for (int i = 0; i < LANES; i++) begin
        e.hdr[i*HDR_W +: HDR_W] = fw[i][31:24];
        e.data[i*DATA_W +: DATA_W] = fw[i][23:0];
      end
      q.push_back(e);
    end
    for (int b = 0; b < nbits; b++) begin
      for (int i = 0; i < LANES; i++) d[i] = fw[i][31-b];
      send_bit(b == 0, d);
    end
  endtask
  task automatic settle(input string tag);
    repeat (40) @(negedge clk_ctrl);
    check({tag, "_pending"}, 128'(q.size()), 128'd0);
    check({tag, "_errs"}, 128'(obs_errs), 128'(exp_errs));
    check({tag, "_err_count"}, 128'(err_count), 128'(exp_errs > 255 ? 255 : exp_errs));
  endtask
  always @(negedge clk_ctrl) begin
    if (sample_valid) begin
      vcount++;
      check("valid_expected", 128'(q.size() != 0), 128'd1);
      if (q.size() != 0) begin
        got_e = q.pop_front();
        check("data", 128'(sample_data), 128'(got_e.data));
        check("hdr", 128'(sample_hdr), 128'(got_e.hdr));
      end
    end
    if (frame_err) begin
      obs_errs++;
      check("valid_err_overlap", 128'(sample_valid), 128'd0);
    end
  end
  initial begin
    frame_t fw;
    logic [LANES*DATA_W-1:0] held;
    int v0, e0;
    repeat (3) @(negedge clk_ctrl);
    rst_n = 1'b1;
    @(negedge clk_ctrl);
    check("rst_valid", 128'(sample_valid), 128'd0);
    check("rst_err", 128'(frame_err), 128'd0);
    check("rst_err_count", 128'(err_count), 128'd0);
    check("rst_state", 128'(rx_state), 128'd0);
    check("rst_data", 128'(sample_data), 128'd0);
    check("rst_hdr", 128'(sample_hdr), 128'd0);
    send_frame(mk(0), 32, 1'b1);
    settle("single");
    v0 = vcount;
    for (int k = 1; k <= 10; k++) send_frame(mk(k), 32, 1'b1);
    settle("b2b");
    check("b2b_valids", 128'(vcount - v0), 128'd10);
    send_frame(mk(11), 17, 1'b1);
    exp_errs++;
    send_frame(mk(12), 32, 1'b1);
    settle("early_drdy");
    send_frame(mk(13), 10, 1'b1);
    dclk = 1'b0;
    repeat (300) @(negedge clk_ctrl);
    exp_errs++;
    check("tmo_errs", 128'(obs_errs), 128'(exp_errs));
    check("tmo_state", 128'(rx_state), 128'd0);
    send_frame(mk(14), 32, 1'b1);
    settle("timeout");
    send_frame(mk(15), 20, 1'b1);
    dclk = 1'b0;
    e0 = obs_errs;
    @(negedge clk_ctrl);
    rst_n = 1'b0;
    @(negedge clk_ctrl);
    rst_n = 1'b1;
    @(negedge clk_ctrl);
    check("mid_rst_data", 128'(sample_data), 128'd0);
    check("mid_rst_hdr", 128'(sample_hdr), 128'd0);
    check("mid_rst_err_count", 128'(err_count), 128'd0);
    check("mid_rst_state", 128'(rx_state), 128'd0);
    repeat (300) @(negedge clk_ctrl);
    check("mid_rst_no_err", 128'(obs_errs), 128'(e0));
    exp_errs = 0;
    obs_errs = 0;
    send_frame(mk(16), 32, 1'b1);
    settle("after_rst");
    fw = mk(17);
    fw[3][31:24] = 8'h80;
    held = sample_data;
    v0 = vcount;
`ifdef ADC_RX_HDR_CHECK_EN
    send_frame(fw, 32, 1'b0);
    exp_errs++;
    settle("hdr_bad");
    check("hdr_bad_no_valid", 128'(vcount - v0), 128'd0);
    check("hdr_bad_data_held", 128'(sample_data), 128'(held));
`else
    send_frame(fw, 32, 1'b1);
    settle("hdr_pass");
    check("hdr_pass_valid", 128'(vcount - v0), 128'd1);
    check("hdr_pass_data_new", 128'(sample_data != held), 128'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
